audio_i2s_out: RTL

- Output stage directly downstream of the voice datapath.
- Takes the 32-bit signed mixed TONE word once per sample period and scales it with saturation to 16 bits.
- Double-buffers the result and serialises it as I2S (mono, duplicated to L and R) to the board audio codec DAC.
- Generates BCLK/LRCK itself and pulses SAMPLE_REQ at each frame start so the synth FSM begins accumulating the next sample.

---
 rtl/audio_i2s_out.sv | 126 ++++++++++++
 1 files changed

// File: rtl/audio_i2s_out.sv
// audio_i2s_out
//   I2S output stage for the voice datapath. Each sample period the final
//   32-bit mixed TONE word is scaled (window [SHIFT+15:SHIFT]) with
//   saturation to 16 bits. The result is held in hold_reg and copied into
//   frame_reg at each frame start. frame_reg is then shifted out MSB first
//   on both the left and the right half of a 64-BCLK I2S frame.
//
// Ports
//   CLK, RESET    system clock; synchronous active-high reset
//   TONE_IN       32-bit signed mixed sample
//   TONE_VALID    one-cycle strobe, TONE_IN final for this period
//   SAMPLE_REQ    one-cycle pulse at frame start (asks for the next sample)
//   AUD_BCLK      I2S bit clock, CLK/(2*BCLK_HALF)
//   AUD_DACLRCK   word select, 0 = left, 1 = right
//   AUD_DACDAT    serial data, changes on BCLK fall
//   CLIP          one-cycle pulse when a saturated sample is latched
//   UNDERRUN      sticky, a frame started without a fresh sample
module audio_i2s_out #(
  parameter int BCLK_HALF = 8,
  parameter int SHIFT     = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] TONE_IN,
  input  logic        TONE_VALID,
  output logic        SAMPLE_REQ,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        CLIP,
  output logic        UNDERRUN
);

  localparam int TOP = SHIFT + 15;
  localparam int DW  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DW-1:0]     div_cnt;
  logic [5:0]        bit_cnt;
  logic [15:0]       hold_reg;
  logic [15:0]       frame_reg;
  logic              fresh;

  // ---------------- conversion ----------------
  // Bits above the window must all match the window's sign bit. When
  // TOP == 31 the check collapses to a single bit and can never clip.
  logic [31-TOP:0]   upper;
  logic [15:0]       cand;
  logic              sat;
  logic [15:0]       conv;
  logic              unused_tone;

  assign upper       = TONE_IN[31:TOP];
  assign cand        = TONE_IN[TOP:SHIFT];
  assign sat         = ~((&upper) | ~(|upper));
  assign conv        = sat ? (TONE_IN[31] ? 16'h8000 : 16'h7FFF) : cand;
  assign unused_tone = ^TONE_IN;

  // ---------------- timing ----------------
  logic        div_tc;
  logic        fall;
  logic [5:0]  bit_nxt;
  logic [4:0]  k;
  logic [4:0]  idx;
  logic        ser_bit;

  assign div_tc  = (div_cnt == DW'(BCLK_HALF - 1));
  assign fall    = div_tc & AUD_BCLK;
  assign bit_nxt = bit_cnt + 6'd1;
  assign k       = bit_nxt[4:0];
  assign idx     = 5'd16 - k;

  // Slot 0 is the I2S one-bit delay; slots 17..31 are padding.
  always_comb begin
    ser_bit = 1'b0;
    if (k >= 5'd1 && k <= 5'd16)
      ser_bit = frame_reg[idx[3:0]];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      hold_reg    <= '0;
      frame_reg   <= '0;
      fresh       <= 1'b0;
      SAMPLE_REQ  <= 1'b0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
      CLIP        <= 1'b0;
      UNDERRUN    <= 1'b0;
    end else begin
      SAMPLE_REQ <= 1'b0;
      CLIP       <= 1'b0;

      if (div_tc) begin
        div_cnt  <= '0;
        AUD_BCLK <= ~AUD_BCLK;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end

      if (TONE_VALID) begin
        hold_reg <= conv;
        fresh    <= 1'b1;
        CLIP     <= sat;
      end

      if (fall) begin
        bit_cnt     <= bit_nxt;
        AUD_DACLRCK <= bit_nxt[5];
        AUD_DACDAT  <= ser_bit;
        if (bit_cnt == 6'd63) begin
          // Frame start. A strobe in this very cycle goes straight into the
          // frame and is consumed by it, so fresh is cleared either way.
          SAMPLE_REQ <= 1'b1;
          fresh      <= 1'b0;
          frame_reg  <= TONE_VALID ? conv : hold_reg;
          if (!fresh && !TONE_VALID)
            UNDERRUN <= 1'b1;
        end
      end
    end
  end

endmodule
